// File: rtl/sw_read_pkg.sv
// Register map, response codes and read FSM encoding shared by the switch read-back slave.
package sw_read_pkg;

   localparam logic [1:0] REG_LEVEL  = 2'd0;
   localparam logic [1:0] REG_CHANGE = 2'd1;
   localparam logic [1:0] REG_INFO   = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [15:0] INFO_MAGIC = 16'h5357;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   function automatic logic [31:0] info_word(input int unsigned width);
      return {INFO_MAGIC, 8'd0, 8'(width)};
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer, free-running tick counter and vector debounce for switch inputs.
// A bit's level follows its sample only when two consecutive tick samples agree.
module sw_debounce #(
   parameter int unsigned Width   = 8,
   parameter int unsigned DebBits = 20
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] sw_i,
   output logic [Width-1:0] level_o,
   output logic [Width-1:0] change_o
);

   logic [Width-1:0]   sync1_q, sync2_q;
   logic [Width-1:0]   sample_q, sample_d;
   logic [Width-1:0]   level_q, level_d;
   logic [DebBits-1:0] cnt_q;
   logic               tick;

   // Counter wraps to zero on the tick edge.
   assign tick = &cnt_q;

   always_comb begin
      sample_d = sample_q;
      level_d  = level_q;
      change_o = '0;
      if (tick) begin
         sample_d = sync2_q;
         change_o = ~(sync2_q ^ sample_q) & (sync2_q ^ level_q);
         level_d  = level_q ^ change_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sample_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sw_i;
         sync2_q  <= sync1_q;
         sample_q <= sample_d;
         level_q  <= level_d;
         cnt_q    <= cnt_q + DebBits'(1);
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/sw_read_logic.sv
// AXI4-Lite read-only slave returning debounced switch levels, a read-to-clear change latch
// and an ID word. Define SW_READ_IRQ_EN to add the irq output (registered OR of CHANGE).
module sw_read_logic
   import sw_read_pkg::*;
#(
   parameter int unsigned sw_width           = 8,
   parameter int unsigned deb_bits           = 20,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic [sw_width-1:0]           sw_in,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [31:0]                   s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready
`ifdef SW_READ_IRQ_EN
   ,
   output logic                          irq
`endif
);

   logic [sw_width-1:0] level, chg_evt, clr_mask;
   logic [sw_width-1:0] change_q, change_d;
   logic [0:0]          state_q, state_d;
   logic                arready_q, arready_d;
   logic                clr_pend_q, clr_pend_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [1:0]          word;
   logic                ar_fire, r_fire;
   logic                unused_addr;

   sw_debounce #(
      .Width   (sw_width),
      .DebBits (deb_bits)
   ) u_debounce (
      .clk_i    (s_axi_aclk),
      .rst_ni   (s_axi_aresetn),
      .sw_i     (sw_in),
      .level_o  (level),
      .change_o (chg_evt)
   );

   assign word        = s_axi_araddr[3:2];
   assign unused_addr = ^s_axi_araddr;
   assign ar_fire     = s_axi_arvalid & arready_q;
   assign r_fire      = (state_q == ST_RESP) & s_axi_rready;

   always_comb begin
      state_d    = state_q;
      arready_d  = arready_q;
      clr_pend_d = clr_pend_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (state_q)
         ST_IDLE: begin
            if (ar_fire) begin
               state_d    = ST_RESP;
               arready_d  = 1'b0;
               clr_pend_d = 1'b0;
               rdata_d    = '0;
               rresp_d    = RESP_OKAY;
               case (word)
                  REG_LEVEL:  rdata_d[sw_width-1:0] = level;
                  REG_CHANGE: begin
                     rdata_d[sw_width-1:0] = change_q;
                     clr_pend_d            = 1'b1;
                  end
                  REG_INFO:   rdata_d = info_word(sw_width);
                  default:    rresp_d = RESP_SLVERR;
               endcase
            end else begin
               // Also holds arready low for one idle cycle after each response.
               arready_d = 1'b1;
            end
         end
         ST_RESP: begin
            if (s_axi_rready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Clear only what was returned; a same-clock change event keeps its bit set.
   assign clr_mask = (r_fire && clr_pend_q) ? rdata_q[sw_width-1:0] : '0;
   assign change_d = (change_q & ~clr_mask) | chg_evt;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q    <= ST_IDLE;
         arready_q  <= 1'b0;
         clr_pend_q <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         change_q   <= '0;
      end else begin
         state_q    <= state_d;
         arready_q  <= arready_d;
         clr_pend_q <= clr_pend_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         change_q   <= change_d;
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = (state_q == ST_RESP);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

`ifdef SW_READ_IRQ_EN
   logic irq_q;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |change_q;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sw_read_logic.sv
// Randomized self-checking bench for sw_read_logic against a cycle-level behavioural model
// (sw_width=8, deb_bits=4). Honours SW_READ_IRQ_EN when defined.
module tb_sw_read_logic;

   localparam int Tick = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  sw_in;
   logic [3:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
`ifdef SW_READ_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: raw input history, debounce, change latch and handshake view.
   int          n;
   logic [7:0]  r1, r2, m_samp, m_level, m_change, m_snap;
   logic        m_arready, m_rvalid, m_pend, m_irq;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;

   sw_read_logic #(
      .sw_width           (8),
      .deb_bits           (4),
      .C_S_AXI_ADDR_WIDTH (4)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .sw_in         (sw_in),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready)
`ifdef SW_READ_IRQ_EN
      ,
      .irq           (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      n = 0; r1 = '0; r2 = '0; m_samp = '0; m_level = '0; m_change = '0; m_snap = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_pend = 1'b0; m_irq = 1'b0;
      m_rdata = '0; m_rresp = 2'b00;
   endtask

   // One clock: model sees the inputs present at the edge, then inputs may change at +1.
   task automatic step();
      logic [7:0] s, ev, clr;
      logic       irq_next;
      @(posedge clk);
      n++;
      s = r2; r2 = r1; r1 = sw_in;
      clr = '0;
      irq_next = |m_change;
      if (m_rvalid) begin
         if (rready) begin
            m_rvalid = 1'b0;
            if (m_pend) clr = m_snap;
         end
      end else if (m_arready && arvalid) begin
         m_arready = 1'b0;
         m_rvalid  = 1'b1;
         m_pend    = 1'b0;
         m_rresp   = 2'b00;
         case (araddr[3:2])
            2'd0: m_rdata = {24'd0, m_level};
            2'd1: begin m_rdata = {24'd0, m_change}; m_snap = m_change; m_pend = 1'b1; end
            2'd2: m_rdata = 32'h5357_0008;
            default: begin m_rdata = '0; m_rresp = 2'b10; end
         endcase
      end else begin
         m_arready = 1'b1;
      end
      ev = '0;
      if (n % Tick == 0) begin
         // Two agreeing tick samples that differ from the level flip it.
         ev = ~(s ^ m_samp) & (s ^ m_level);
         m_level = m_level ^ ev;
         m_samp = s;
      end
      m_change = (m_change & ~clr) | ev;
      m_irq = irq_next;
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic do_read(input logic [3:0] addr, input int hold, input string tag,
                          output logic [31:0] data, output logic [1:0] resp);
      int guard;
      guard = 0;
      araddr = addr;
      arvalid = 1'b1;
      while (!m_arready && guard < 8) begin
         step();
         guard++;
      end
      check_eq({tag, " arready"}, 32'(arready), 32'(m_arready));
      check_eq({tag, " rvalid_pre"}, 32'(rvalid), 32'd0);
      step();
      arvalid = 1'b0;
      araddr = 4'($urandom);
      check_eq({tag, " rvalid"}, 32'(rvalid), 32'd1);
      check_eq({tag, " rdata"}, rdata, m_rdata);
      check_eq({tag, " rresp"}, 32'(rresp), 32'(m_rresp));
      data = rdata;
      resp = rresp;
      for (int h = 0; h < hold; h++) begin
         step();
         check_eq({tag, " hold_rdata"}, rdata, m_rdata);
         check_eq({tag, " hold_rresp"}, 32'(rresp), 32'(m_rresp));
         check_eq({tag, " hold_arready"}, 32'(arready), 32'd0);
         check_eq({tag, " hold_rvalid"}, 32'(rvalid), 32'd1);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      check_eq({tag, " rvalid_done"}, 32'(rvalid), 32'd0);
      check_eq({tag, " arready_gap"}, 32'(arready), 32'd0);
`ifdef SW_READ_IRQ_EN
      check_eq({tag, " irq"}, 32'(irq), 32'(m_irq));
`endif
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      rst_n = 1'b0; sw_in = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_eq("reset arready", 32'(arready), 32'd0);
      check_eq("reset rvalid", 32'(rvalid), 32'd0);
      check_eq("reset rdata", rdata, 32'd0);
      check_eq("reset rresp", 32'(rresp), 32'd0);
`ifdef SW_READ_IRQ_EN
      check_eq("reset irq", 32'(irq), 32'd0);
`endif
      rst_n = 1'b1;
      step();
      check_eq("arready after reset", 32'(arready), 32'd1);

      do_read(4'h8, 0, "info", d, r);
      check_eq("info value", d, 32'h5357_0008);
      check_eq("info resp", 32'(r), 32'd0);

      sw_in = 8'hA5;
      idle(40);
      do_read(4'h0, 0, "level_a5", d, r);
      check_eq("level_a5 value", d, 32'h0000_00A5);
      do_read(4'h4, 0, "change_a5", d, r);
      check_eq("change_a5 value", d, 32'h0000_00A5);
      do_read(4'h4, 0, "change_clr", d, r);
      check_eq("change_clr value", d, 32'd0);

      // Settle to zero, clear, then toggle bit0 too fast to survive debouncing.
      sw_in = 8'h00;
      idle(40);
      do_read(4'h4, 1, "change_fall", d, r);
      while (n % Tick != 0) step();
      for (int i = 0; i < 60; i++) begin
         if (i % 5 == 0) sw_in[0] = ~sw_in[0];
         step();
      end
      do_read(4'h0, 0, "bounce_level", d, r);
      check_eq("bounce level bit0", 32'(d[0]), 32'd0);
      do_read(4'h4, 0, "bounce_change", d, r);
      check_eq("bounce change", d, 32'd0);

      do_read(4'h1, 10, "stall", d, r);
      do_read(4'hC, 0, "unmapped", d, r);
      check_eq("unmapped rdata", d, 32'd0);
      check_eq("unmapped rresp", 32'(r), 32'd2);
      do_read(4'h3, 0, "after_err", d, r);
      check_eq("after_err rresp", 32'(r), 32'd0);

      // Bit1 set in CHANGE, then its falling event lands on the clearing rready edge.
      sw_in = 8'h02;
      idle(40);
      while (n % Tick != 0) step();
      sw_in = 8'h00;
      do_read(4'h4, 30, "race_clr", d, r);
      check_eq("race snapshot", d, 32'h0000_0002);
      do_read(4'h4, 0, "race_after", d, r);
      check_eq("race bit1 kept", 32'(d[1]), 32'd1);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) != 0) sw_in = 8'($urandom);
         idle($urandom_range(0, 40));
         do_read(4'($urandom), $urandom_range(0, 3), "rand", d, r);
      end

      // Reset while a response is pending: rvalid must drop without a clock.
      while (!m_arready) step();
      araddr = 4'h4;
      arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      check_eq("midrst rvalid_before", 32'(rvalid), 32'(m_rvalid));
      rst_n = 1'b0;
      #1;
      check_eq("midrst rvalid", 32'(rvalid), 32'd0);
      check_eq("midrst arready", 32'(arready), 32'd0);
      check_eq("midrst rdata", rdata, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      do_read(4'h8, 0, "post_rst", d, r);
      check_eq("post_rst info", d, 32'h5357_0008);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
